// File: rtl/irom_pkg.sv
// Shared types and constants for the loadable instruction ROM.
// IROM_PARITY_EN adds one even-parity bit per stored word.
package irom_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } irom_state_e;

   localparam logic [31:0] IROM_NOP_DEFAULT = 32'd0;
   localparam int unsigned IROM_OFF_W       = 2;
   localparam int unsigned IROM_WORD_W      = 32;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [IROM_WORD_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/irom_storage.sv
// Simple dual-port word array: one synchronous write port, one registered read port.
// The read register only updates when re_i is high, so its output holds otherwise.
module irom_storage #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 7
) (
   input  logic             clock,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clock) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_rom_loadable.sv
// Instruction ROM that clears itself, accepts a program from a loader, then serves fetches.
// Define IROM_PARITY_EN to store and check an even-parity bit per word.
module instr_rom_loadable
   import irom_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 128,
   parameter int unsigned ADDR_W      = 32,
   parameter logic [31:0] NOP_WORD    = IROM_NOP_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_valid,
   output logic [31:0]       fetch_data,
   output logic              fetch_err,
   output logic              state_run
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH_WORDS - 1);
`ifdef IROM_PARITY_EN
   localparam int unsigned MEM_W = IROM_WORD_W + 1;
`else
   localparam int unsigned MEM_W = IROM_WORD_W;
`endif

   irom_state_e        state_q, state_d;
   logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [IDX_W-1:0]   ld_cnt_q, ld_cnt_d;

   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx;
   logic [31:0]        wr_word;
   logic [MEM_W-1:0]   wr_data;
   logic [MEM_W-1:0]   rd_data;

   logic               in_run;
   logic               misaligned;
   logic               out_of_range;
   logic               use_mem;
   logic               addr_err;
   logic               parity_bad;

   logic               fetch_valid_q;
   logic               use_mem_q;
   logic               err_q;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ld_cnt_d  = ld_cnt_q;
      wr_en     = 1'b0;
      wr_idx    = clr_cnt_q;
      wr_word   = NOP_WORD;
      case (state_q)
         ST_CLEAR: begin
            wr_en     = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_MAX) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (load_valid) begin
               wr_en    = 1'b1;
               wr_idx   = ld_cnt_q;
               wr_word  = load_data;
               ld_cnt_d = ld_cnt_q + 1'b1;
               if (load_last || (ld_cnt_q == IDX_MAX)) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ld_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ld_cnt_q  <= ld_cnt_d;
      end
   end

   assign load_ready = (state_q == ST_LOAD);
   assign state_run  = (state_q == ST_RUN);

`ifdef IROM_PARITY_EN
   assign wr_data = {even_parity(wr_word), wr_word};
`else
   assign wr_data = wr_word;
`endif

   irom_storage #(
      .DEPTH (DEPTH_WORDS),
      .WIDTH (MEM_W),
      .AW    (IDX_W)
   ) u_storage (
      .clock   (clock),
      .we_i    (wr_en),
      .waddr_i (wr_idx),
      .wdata_i (wr_data),
      .re_i    (fetch_req),
      .raddr_i (fetch_addr[IROM_OFF_W +: IDX_W]),
      .rdata_o (rd_data)
   );

   // Any address bit above the word index means the fetch is beyond the array.
   assign in_run       = (state_q == ST_RUN);
   assign misaligned   = (fetch_addr[IROM_OFF_W-1:0] != '0);
   assign out_of_range = ((fetch_addr >> (IROM_OFF_W + IDX_W)) != '0);
   assign use_mem      = in_run && !misaligned && !out_of_range;
   assign addr_err     = in_run && (misaligned || out_of_range);

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_valid_q <= 1'b0;
         use_mem_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         fetch_valid_q <= fetch_req;
         if (fetch_req) begin
            use_mem_q <= use_mem;
            err_q     <= addr_err;
         end
      end
   end

`ifdef IROM_PARITY_EN
   assign parity_bad = (rd_data[IROM_WORD_W] != even_parity(rd_data[IROM_WORD_W-1:0]));
`else
   assign parity_bad = 1'b0;
`endif

   // The response is rebuilt from held flags and the held read register,
   // so it stays stable between requests without a separate data register.
   assign fetch_valid = fetch_valid_q;
   assign fetch_data  = (use_mem_q && !parity_bad) ? rd_data[IROM_WORD_W-1:0] : NOP_WORD;
   assign fetch_err   = err_q || (use_mem_q && parity_bad);

endmodule

// File: tb/tb_instr_rom_loadable.sv
// Self-checking bench for instr_rom_loadable with DEPTH_WORDS=16.
// Under IROM_PARITY_EN it also injects a stored bit flip.
module tb_instr_rom_loadable;

   localparam int          DEPTH   = 16;
   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam int          P_CLEAR = 0;
   localparam int          P_LOAD  = 1;
   localparam int          P_RUN   = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_last;
   logic        load_ready;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_err;
   logic        state_run;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   instr_rom_loadable #(
      .DEPTH_WORDS (DEPTH),
      .ADDR_W      (32),
      .NOP_WORD    (NOP)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_err   (fetch_err),
      .state_run   (state_run)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: phase, a word array, and the expected response.
   int          phase  = -1;
   int          cleared;
   int          loaded;
   int unsigned widx;
   logic [31:0] mmem [DEPTH];
   bit          mbad [DEPTH];
   logic        m_valid;
   logic        m_err;
   logic [31:0] m_data;

   always @(posedge clock) begin
      if (reset) begin
         phase   = P_CLEAR;
         cleared = 0;
         loaded  = 0;
         m_valid = 1'b0;
         m_err   = 1'b0;
         m_data  = NOP;
      end else if (phase >= 0) begin
         m_valid = fetch_req;
         if (fetch_req) begin
            widx = fetch_addr / 4;
            if (phase != P_RUN) begin
               m_data = NOP; m_err = 1'b0;
            end else if ((fetch_addr % 4) != 0 || widx >= DEPTH) begin
               m_data = NOP; m_err = 1'b1;
            end else if (mbad[widx]) begin
               m_data = NOP; m_err = 1'b1;
            end else begin
               m_data = mmem[widx]; m_err = 1'b0;
            end
         end
         case (phase)
            P_CLEAR: begin
               cleared++;
               if (cleared == DEPTH) begin
                  foreach (mmem[i]) begin
                     mmem[i] = NOP;
                     mbad[i] = 1'b0;
                  end
                  phase = P_LOAD;
               end
            end
            P_LOAD: begin
               if (load_valid) begin
                  mmem[loaded] = load_data;
                  loaded++;
                  if (load_last || loaded == DEPTH) phase = P_RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always @(negedge clock) begin
      if (phase >= 0) begin
         chk("load_ready", load_ready, phase == P_LOAD);
         chk("state_run", state_run, phase == P_RUN);
         chk("fetch_valid", fetch_valid, m_valid);
         chk("fetch_data", fetch_data, m_data);
         chk("fetch_err", fetch_err, m_err);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (load_ready !== 1'b1 && n < 200) begin
         @(posedge clock);
         #1;
         n++;
      end
      chk("wait_ready", load_ready, 1'b1);
   endtask

   task automatic load(input logic [31:0] d, input logic l);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = l;
      @(posedge clock);
      #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic fetch_chk(input logic [31:0] a, input logic [31:0] ed, input logic ee);
      fetch_req  = 1'b1;
      fetch_addr = a;
      @(posedge clock);
      #1;
      fetch_req = 1'b0;
      chk("lit_valid", fetch_valid, 1'b1);
      chk("lit_data", fetch_data, ed);
      chk("lit_err", fetch_err, ee);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] burst [4];
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Clear sweep: sixteen cycles with the loader held off.
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clock);
         chk("clr_ready", load_ready, 1'b0);
         chk("clr_run", state_run, 1'b0);
      end
      @(negedge clock);
      chk("ready_after_clear", load_ready, 1'b1);
      @(posedge clock);
      #1;

      fetch_chk(32'h4, NOP, 1'b0);
      load(32'h80010A0A, 1'b0);
      load(32'h04011000, 1'b0);
      load(32'h0C011800, 1'b1);
      chk("run_entered", state_run, 1'b1);
      chk("ready_dropped", load_ready, 1'b0);

      fetch_chk(32'h0, 32'h80010A0A, 1'b0);
      fetch_chk(32'h4, 32'h04011000, 1'b0);
      fetch_chk(32'h8, 32'h0C011800, 1'b0);
      fetch_chk(32'hC, 32'h00000000, 1'b0);
      fetch_chk(32'h6, NOP, 1'b1);
      fetch_chk(32'h40, NOP, 1'b1);
      fetch_chk(32'h3C, NOP, 1'b0);
      fetch_chk(32'hFFFF_FFFC, NOP, 1'b1);
      fetch_chk(32'h1, NOP, 1'b1);

      // Back-to-back fetches, then idle cycles where the response must hold.
      burst[0] = 32'h8; burst[1] = 32'h0; burst[2] = 32'h4; burst[3] = 32'h41;
      fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         fetch_addr = burst[i];
         @(posedge clock);
         #1;
      end
      fetch_req = 1'b0;
      fetch_addr = 32'h0;
      idle(3);

      // Loader activity in RUN must be ignored.
      load_valid = 1'b1;
      load_data  = 32'hDEADBEEF;
      idle(2);
      chk("run_ready_low", load_ready, 1'b0);
      load_valid = 1'b0;
      fetch_chk(32'hC, 32'h00000000, 1'b0);

      // Overlong load without load_last stops after the last word slot.
      do_reset();
      wait_ready();
      for (int i = 0; i < 20; i++) begin
         if (i >= DEPTH) chk("ready_low_extra", load_ready, 1'b0);
         load(32'hA0000000 + i, 1'b0);
      end
      chk("run_after_full", state_run, 1'b1);
      fetch_chk(32'h3C, 32'hA000000F, 1'b0);
      fetch_chk(32'h0, 32'hA0000000, 1'b0);

      // Reset mid-load with a fetch in the reset cycle.
      do_reset();
      wait_ready();
      load(32'hB1B1B1B1, 1'b0);
      load(32'hB2B2B2B2, 1'b0);
      reset      = 1'b1;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      @(posedge clock);
      #1;
      reset     = 1'b0;
      fetch_req = 1'b0;
      chk("no_valid_after_reset", fetch_valid, 1'b0);
      chk("run_low_after_reset", state_run, 1'b0);
      wait_ready();
      load(32'hC1C1C1C1, 1'b1);
      fetch_chk(32'h0, 32'hC1C1C1C1, 1'b0);
      fetch_chk(32'h4, 32'h00000000, 1'b0);

`ifdef IROM_PARITY_EN
      dut.u_storage.mem_q[1] = dut.u_storage.mem_q[1] ^ 33'h1;
      mbad[1] = 1'b1;
      fetch_chk(32'h4, NOP, 1'b1);
      fetch_chk(32'h0, 32'hC1C1C1C1, 1'b0);
`endif

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
